register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 96 +++++++++
 tb/tb_register_file.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32-entry register file: two combinational read ports with write bypass,
// one write port, and a sequential dump engine that streams every entry out.
module register_file #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         write_enable,
  input  logic [4:0]   write_addr,
  input  logic [n-1:0] write_data,
  input  logic [4:0]   read_addr1,
  output logic [n-1:0] read_data1,
  input  logic [4:0]   read_addr2,
  output logic [n-1:0] read_data2,
  input  logic         dump_start,
  output logic         dump_valid,
  output logic [4:0]   dump_index,
  output logic [n-1:0] dump_data,
  output logic         dump_done
);

  typedef enum logic {IDLE, DUMP} state_t;

  state_t       state, state_next;
  logic [n-1:0] mem [32];
  logic [4:0]   index_q, index_next;
  logic         done_q, done_next;
  logic [n-1:0] dump_read;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) mem[i] <= '0;
    end else if (write_enable && write_addr != '0) begin
      mem[write_addr] <= write_data;
    end
  end

  // Entry 0 is forced to zero on every read path; a matching write is
  // forwarded so a reader sees the value being written this cycle.
  assign read_data1 = (read_addr1 == '0) ? '0 :
                      (write_enable && write_addr == read_addr1) ? write_data :
                      mem[read_addr1];
  assign read_data2 = (read_addr2 == '0) ? '0 :
                      (write_enable && write_addr == read_addr2) ? write_data :
                      mem[read_addr2];
  assign dump_read  = (index_q == '0) ? '0 :
                      (write_enable && write_addr == index_q) ? write_data :
                      mem[index_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      index_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      index_q <= index_next;
      done_q  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    index_next = index_q;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_next = DUMP;
          index_next = '0;
        end
      end
      DUMP: begin
        if (index_q == 5'd31) begin
          state_next = IDLE;
          index_next = '0;
          done_next  = 1'b1;
        end else begin
          index_next = index_q + 5'd1;
        end
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

  always_comb begin
    dump_valid = (state == DUMP);
    dump_index = index_q;
    dump_done  = done_q;
    dump_data  = dump_valid ? dump_read : '0;
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a per-cycle reference model checked on every
// falling edge, plus directed scenarios with literal expectations.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [31:0] read_data1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data2;
  logic        dump_start;
  logic        dump_valid;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;
  logic        dump_done;

  int checks = 0;
  int errors = 0;

  register_file #(.n(32)) dut (
    .clk(clk), .reset(reset),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .read_addr1(read_addr1), .read_data1(read_data1),
    .read_addr2(read_addr2), .read_data2(read_data2),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_index(dump_index),
    .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  // Reference model: stored contents, items still to be dumped, done pulse.
  logic [31:0] m_mem [32];
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          m_ok   = 1'b0;

  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return 32'h0;
    if (write_enable && int'(write_addr) == a) return write_data;
    return m_mem[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_left = 0;
      m_done = 1'b0;
      m_ok   = 1'b1;
    end else begin
      if (write_enable && write_addr != 5'd0) m_mem[write_addr] = write_data;
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) m_done = 1'b1;
      end else if (dump_start) begin
        m_left = 32;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      automatic bit v = (m_left > 0);
      automatic int idx = v ? 32 - m_left : 0;
      chk("read_data1", read_data1, m_read(int'(read_addr1)));
      chk("read_data2", read_data2, m_read(int'(read_addr2)));
      chk("dump_valid", {31'b0, dump_valid}, {31'b0, v});
      chk("dump_index", {27'b0, dump_index}, idx);
      chk("dump_data",  dump_data, v ? m_read(idx) : 32'h0);
      chk("dump_done",  {31'b0, dump_done}, {31'b0, m_done});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; write_enable = 1'b0; write_addr = '0; write_data = '0;
    read_addr1 = '0; read_addr2 = '0; dump_start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, dump_valid}, 32'h0);
    chk("rst_done",  {31'b0, dump_done}, 32'h0);
    chk("rst_index", {27'b0, dump_index}, 32'h0);
    read_addr1 = 5'd9;
    #1 chk("rst_entry9", read_data1, 32'h0);

    // write then read back; port 2 on entry 0
    tick();
    write_enable = 1'b1; write_addr = 5'd5; write_data = 32'hDEADBEEF;
    tick();
    write_enable = 1'b0; read_addr1 = 5'd5; read_addr2 = 5'd0;
    @(negedge clk);
    chk("lit_rd5", read_data1, 32'hDEADBEEF);
    chk("lit_rd0", read_data2, 32'h0);

    // write to entry 0 is discarded
    tick();
    write_enable = 1'b1; write_addr = 5'd0; write_data = 32'hFFFFFFFF; read_addr1 = 5'd0;
    tick();
    write_enable = 1'b0;
    @(negedge clk);
    chk("lit_zero", read_data1, 32'h0);

    // same-cycle bypass on both ports
    tick();
    write_enable = 1'b1; write_addr = 5'd7; write_data = 32'h12345678;
    read_addr1 = 5'd7; read_addr2 = 5'd7;
    @(negedge clk);
    chk("lit_byp1", read_data1, 32'h12345678);
    chk("lit_byp2", read_data2, 32'h12345678);
    tick();
    write_enable = 1'b0;

    // fill i*0x11 then full dump with dump_start held throughout
    for (int i = 1; i < 32; i++) begin
      write_enable = 1'b1; write_addr = 5'(i); write_data = 32'(i * 'h11);
      tick();
    end
    write_enable = 1'b0; read_addr1 = 5'd31; read_addr2 = 5'd16;
    dump_start = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("lit_dvalid", {31'b0, dump_valid}, 32'h1);
      chk("lit_dindex", {27'b0, dump_index}, 32'(k));
      chk("lit_ddata",  dump_data, 32'(k * 'h11));
      tick();
    end
    dump_start = 1'b0;
    @(negedge clk);
    chk("lit_done",    {31'b0, dump_done}, 32'h1);
    chk("lit_idle",    {31'b0, dump_valid}, 32'h0);
    chk("lit_idle_dd", dump_data, 32'h0);
    tick();
    @(negedge clk);
    chk("lit_done_end", {31'b0, dump_done}, 32'h0);
    chk("lit_norestart", {31'b0, dump_valid}, 32'h0);

    // write into the entry currently being dumped
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    write_enable = 1'b1; write_addr = 5'd10; write_data = 32'hAAAA0000;
    @(negedge clk);
    chk("lit_dbyp_idx",  {27'b0, dump_index}, 32'd10);
    chk("lit_dbyp_data", dump_data, 32'hAAAA0000);
    tick();
    write_enable = 1'b0;
    tick();
    @(negedge clk);
    chk("lit_idx12", {27'b0, dump_index}, 32'd12);

    // reset mid-dump aborts without a done pulse
    reset = 1'b1;
    tick();
    reset = 1'b0; read_addr1 = 5'd10; read_addr2 = 5'd7;
    @(negedge clk);
    chk("lit_abort_valid", {31'b0, dump_valid}, 32'h0);
    chk("lit_abort_done",  {31'b0, dump_done}, 32'h0);
    chk("lit_abort_rd1",   read_data1, 32'h0);
    chk("lit_abort_rd2",   read_data2, 32'h0);
    for (int k = 0; k < 4; k++) tick();

    // reset wins over a simultaneous write and dump_start
    write_enable = 1'b1; write_addr = 5'd3; write_data = 32'h55AA55AA;
    dump_start = 1'b1; reset = 1'b1; read_addr1 = 5'd4;
    tick();
    reset = 1'b0; write_enable = 1'b0; dump_start = 1'b0; read_addr1 = 5'd3;
    @(negedge clk);
    chk("lit_rprio_rd",    read_data1, 32'h0);
    chk("lit_rprio_valid", {31'b0, dump_valid}, 32'h0);

    // a few random writes/reads for the model to track
    for (int k = 0; k < 40; k++) begin
      tick();
      write_enable = 1'($urandom_range(0, 1));
      write_addr   = 5'($urandom_range(0, 31));
      write_data   = $urandom;
      read_addr1   = 5'($urandom_range(0, 31));
      read_addr2   = write_addr;
      dump_start   = (k == 3);
    end
    tick();
    write_enable = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
